parking_zone_controller: RTL and testbench

//  Clocked, parametrised two-zone (university / public) parking occupancy controller. Accepts entry and

---
 rtl/parking_zone_controller_pkg.sv | 15 +
 rtl/parking_zone_controller_if.sv | 31 +++
 rtl/parking_zone_controller_capacity_calc.sv | 50 +++++
 rtl/parking_zone_controller.sv | 203 ++++++++++++++++++++
 tb/tb_parking_zone_controller.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/parking_zone_controller_pkg.sv
// Shared types for the parking zone controller.
//   state_t  : controller FSM states
//   ZONE_*   : encoding of entry_zone / exit_is_uni / entry_is_uni
package parking_zone_controller_pkg;

  typedef enum logic [1:0] {
    ST_CLOSED   = 2'd0,
    ST_OPEN     = 2'd1,
    ST_RECONFIG = 2'd2
  } state_t;

  localparam logic ZONE_UNI = 1'b1;
  localparam logic ZONE_PUB = 1'b0;

endpackage

// File: rtl/parking_zone_controller_if.sv
// Gate-side entry/exit handshake bundle.
//   master : gate sensors / ticket logic (drives requests, sees results)
//   slave  : parking_zone_controller
interface parking_zone_controller_if;

  logic entry_valid;
  logic entry_is_uni;
  logic entry_ready;
  logic entry_done;
  logic entry_grant;
  logic entry_zone;

  logic exit_valid;
  logic exit_is_uni;
  logic exit_ready;
  logic exit_done;
  logic exit_ok;

  modport master (
    output entry_valid, entry_is_uni, exit_valid, exit_is_uni,
    input  entry_ready, entry_done, entry_grant, entry_zone,
    input  exit_ready, exit_done, exit_ok
  );

  modport slave (
    input  entry_valid, entry_is_uni, exit_valid, exit_is_uni,
    output entry_ready, entry_done, entry_grant, entry_zone,
    output exit_ready, exit_done, exit_ok
  );

endinterface

// File: rtl/parking_zone_controller_capacity_calc.sv
// Combinational hour-of-day -> zone capacity targets.
//   hour    : 0..23, values above 23 treated as 23
//   uni_cap : university zone target capacity
//   pub_cap : public zone target capacity (TOTAL_SPACES - uni_cap)
module parking_zone_controller_capacity_calc #(
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned TOTAL_SPACES = 700,
  parameter int unsigned UNI_MAX      = 500,
  parameter int unsigned UNI_MIN      = 200,
  parameter int unsigned RAMP_START   = 13,
  parameter int unsigned RAMP_END     = 16,
  parameter int unsigned RAMP_STEP    = 50
) (
  input  logic [4:0]       hour,
  output logic [CNT_W-1:0] uni_cap,
  output logic [CNT_W-1:0] pub_cap
);

  localparam int unsigned W = CNT_W + 4;

  logic [4:0]   h;
  logic [W-1:0] steps;
  logic [W-1:0] dec;
  logic [W-1:0] uni_w;
  logic [W-1:0] pub_w;

  // Ramp-down is clamped at UNI_MIN before subtracting so nothing can wrap.
  always_comb begin
    h     = (hour > 5'd23) ? 5'd23 : hour;
    steps = '0;
    dec   = '0;
    if (32'(h) < RAMP_START) begin
      uni_w = W'(UNI_MAX);
    end else if (32'(h) < RAMP_END) begin
      steps = W'(h) - W'(RAMP_START) + W'(1);
      dec   = steps * W'(RAMP_STEP);
      if (dec >= W'(UNI_MAX - UNI_MIN)) begin
        uni_w = W'(UNI_MIN);
      end else begin
        uni_w = W'(UNI_MAX) - dec;
      end
    end else begin
      uni_w = W'(UNI_MIN);
    end
    pub_w   = W'(TOTAL_SPACES) - uni_w;
    uni_cap = CNT_W'(uni_w);
    pub_cap = CNT_W'(pub_w);
  end

endmodule

// File: rtl/parking_zone_controller.sv
// Two-zone (university / public) parking occupancy controller.
//   clk, rst_n          : clock, asynchronous active-low reset
//   hour                : hour of day (drives capacity targets and open/closed)
//   gate                : entry/exit handshakes (slave side)
//   uni_cnt / pub_cnt   : parked cars per zone
//   uni_cap / pub_cap   : current zone capacities
//   uni_vac / pub_vac   : cap - cnt, saturating at 0
//   uni_full / pub_full : cnt >= cap
//   open                : controller in OPEN state
module parking_zone_controller
  import parking_zone_controller_pkg::*;
#(
  parameter int unsigned CNT_W        = 10,
  parameter int unsigned TOTAL_SPACES = 700,
  parameter int unsigned UNI_MAX      = 500,
  parameter int unsigned UNI_MIN      = 200,
  parameter int unsigned OPEN_HOUR    = 8,
  parameter int unsigned RAMP_START   = 13,
  parameter int unsigned RAMP_END     = 16,
  parameter int unsigned RAMP_STEP    = 50
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4:0]               hour,
  parking_zone_controller_if.slave gate,
  output logic [CNT_W-1:0]         uni_cnt,
  output logic [CNT_W-1:0]         pub_cnt,
  output logic [CNT_W-1:0]         uni_cap,
  output logic [CNT_W-1:0]         pub_cap,
  output logic [CNT_W-1:0]         uni_vac,
  output logic [CNT_W-1:0]         pub_vac,
  output logic                     uni_full,
  output logic                     pub_full,
  output logic                     open
);

  state_t state_q, state_d;

  logic [CNT_W-1:0] uni_tgt, pub_tgt;
  logic [CNT_W-1:0] uni_cnt_d, pub_cnt_d, uni_cap_d, pub_cap_d;
  logic [CNT_W-1:0] uni_vac_d, pub_vac_d;
  logic             uni_full_d, pub_full_d;
  logic             ready_q, ready_d;
  logic             entry_done_d, entry_grant_d, entry_zone_d;
  logic             exit_done_d, exit_ok_d;
  logic             entry_done_q, entry_grant_q, entry_zone_q;
  logic             exit_done_q, exit_ok_q;
  logic             open_d;
  logic             hour_open;
  logic             entry_fire, exit_fire;
  logic             uni_room, pub_room;

  parking_zone_controller_capacity_calc #(
    .CNT_W       (CNT_W),
    .TOTAL_SPACES(TOTAL_SPACES),
    .UNI_MAX     (UNI_MAX),
    .UNI_MIN     (UNI_MIN),
    .RAMP_START  (RAMP_START),
    .RAMP_END    (RAMP_END),
    .RAMP_STEP   (RAMP_STEP)
  ) u_capacity_calc (
    .hour   (hour),
    .uni_cap(uni_tgt),
    .pub_cap(pub_tgt)
  );

  assign hour_open  = (32'(hour) >= OPEN_HOUR);
  assign entry_fire = gate.entry_valid & ready_q;
  assign exit_fire  = gate.exit_valid & ready_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLOSED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next values of every registered output.
  always_comb begin
    state_d       = state_q;
    uni_cnt_d     = uni_cnt;
    pub_cnt_d     = pub_cnt;
    uni_cap_d     = uni_cap;
    pub_cap_d     = pub_cap;
    entry_done_d  = 1'b0;
    entry_grant_d = 1'b0;
    entry_zone_d  = ZONE_PUB;
    exit_done_d   = 1'b0;
    exit_ok_d     = 1'b0;
    uni_room      = 1'b0;
    pub_room      = 1'b0;

    case (state_q)
      ST_RECONFIG: state_d = hour_open ? ST_OPEN : ST_CLOSED;
      default: begin
        if (uni_tgt != uni_cap) begin
          state_d = ST_RECONFIG;
        end else begin
          state_d = hour_open ? ST_OPEN : ST_CLOSED;
        end
      end
    endcase

    // Exit first so a same-cycle entry sees the freed space.
    if (exit_fire) begin
      exit_done_d = 1'b1;
      if (gate.exit_is_uni == ZONE_UNI) begin
        if (uni_cnt_d != '0) begin
          uni_cnt_d = uni_cnt_d - CNT_W'(1);
          exit_ok_d = 1'b1;
        end
      end else begin
        if (pub_cnt_d != '0) begin
          pub_cnt_d = pub_cnt_d - CNT_W'(1);
          exit_ok_d = 1'b1;
        end
      end
    end

    // Uni cars overflow to public; public cars never take uni spaces.
    if (entry_fire) begin
      entry_done_d = 1'b1;
      uni_room     = (uni_cnt_d < uni_cap);
      pub_room     = (pub_cnt_d < pub_cap);
      if (state_q == ST_OPEN) begin
        if (gate.entry_is_uni == ZONE_UNI && uni_room) begin
          uni_cnt_d     = uni_cnt_d + CNT_W'(1);
          entry_grant_d = 1'b1;
          entry_zone_d  = ZONE_UNI;
        end else if (pub_room) begin
          pub_cnt_d     = pub_cnt_d + CNT_W'(1);
          entry_grant_d = 1'b1;
          entry_zone_d  = ZONE_PUB;
        end
      end
    end

    // Capacity load; surplus uni cars are recounted as public (total conserved).
    if (state_q == ST_RECONFIG) begin
      uni_cap_d = uni_tgt;
      pub_cap_d = pub_tgt;
      if (uni_cnt > uni_tgt) begin
        pub_cnt_d = pub_cnt + (uni_cnt - uni_tgt);
        uni_cnt_d = uni_tgt;
      end
    end

    uni_vac_d  = (uni_cap_d > uni_cnt_d) ? (uni_cap_d - uni_cnt_d) : '0;
    pub_vac_d  = (pub_cap_d > pub_cnt_d) ? (pub_cap_d - pub_cnt_d) : '0;
    uni_full_d = (uni_cnt_d >= uni_cap_d);
    pub_full_d = (pub_cnt_d >= pub_cap_d);
    ready_d    = (state_d != ST_RECONFIG);
    open_d     = (state_d == ST_OPEN);
  end

  // Count, capacity, status and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uni_cnt       <= '0;
      pub_cnt       <= '0;
      uni_cap       <= CNT_W'(UNI_MAX);
      pub_cap       <= CNT_W'(TOTAL_SPACES - UNI_MAX);
      uni_vac       <= CNT_W'(UNI_MAX);
      pub_vac       <= CNT_W'(TOTAL_SPACES - UNI_MAX);
      uni_full      <= 1'b0;
      pub_full      <= 1'b0;
      open          <= 1'b0;
      ready_q       <= 1'b0;
      entry_done_q  <= 1'b0;
      entry_grant_q <= 1'b0;
      entry_zone_q  <= 1'b0;
      exit_done_q   <= 1'b0;
      exit_ok_q     <= 1'b0;
    end else begin
      uni_cnt       <= uni_cnt_d;
      pub_cnt       <= pub_cnt_d;
      uni_cap       <= uni_cap_d;
      pub_cap       <= pub_cap_d;
      uni_vac       <= uni_vac_d;
      pub_vac       <= pub_vac_d;
      uni_full      <= uni_full_d;
      pub_full      <= pub_full_d;
      open          <= open_d;
      ready_q       <= ready_d;
      entry_done_q  <= entry_done_d;
      entry_grant_q <= entry_grant_d;
      entry_zone_q  <= entry_zone_d;
      exit_done_q   <= exit_done_d;
      exit_ok_q     <= exit_ok_d;
    end
  end

  assign gate.entry_ready = ready_q;
  assign gate.exit_ready  = ready_q;
  assign gate.entry_done  = entry_done_q;
  assign gate.entry_grant = entry_grant_q;
  assign gate.entry_zone  = entry_zone_q;
  assign gate.exit_done   = exit_done_q;
  assign gate.exit_ok     = exit_ok_q;

endmodule

// File: tb/tb_parking_zone_controller.sv
// Directed self-checking bench for parking_zone_controller.
module tb_parking_zone_controller;

  localparam int unsigned CNT_W = 10;

  logic             clk;
  logic             rst_n;
  logic [4:0]       hour;
  logic [CNT_W-1:0] uni_cnt, pub_cnt, uni_cap, pub_cap, uni_vac, pub_vac;
  logic             uni_full, pub_full, open;

  parking_zone_controller_if pif ();

  parking_zone_controller dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hour    (hour),
    .gate    (pif),
    .uni_cnt (uni_cnt),
    .pub_cnt (pub_cnt),
    .uni_cap (uni_cap),
    .pub_cap (pub_cap),
    .uni_vac (uni_vac),
    .pub_vac (pub_vac),
    .uni_full(uni_full),
    .pub_full(pub_full),
    .open    (open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic ev, eu, xv, xu;
    logic edone, grant, zone, xdone, ok;
    int   ucnt, pcnt, uvac, pvac;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic eu, input logic xv, input logic xu);
    pif.entry_valid  = ev;
    pif.entry_is_uni = eu;
    pif.exit_valid   = xv;
    pif.exit_is_uni  = xu;
  endtask

  // Called at posedge+1: hold a request for n edges, then release.
  task automatic burst(input logic ev, input logic eu, input logic xv, input logic xu,
                       input int n);
    drive(ev, eu, xv, xu);
    repeat (n) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One-cycle transaction; results sampled 1 time unit after the edge.
  task automatic step(input logic ev, input logic eu, input logic xv, input logic xu);
    drive(ev, eu, xv, xu);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_counts(input string tag, input int u, input int p);
    chk({tag, " uni_cnt"}, int'(uni_cnt), u);
    chk({tag, " pub_cnt"}, int'(pub_cnt), p);
  endtask

  initial begin
    vecs[0] = '{1,1,0,0, 1,1,1,0,0, 1,0,499,200};
    vecs[1] = '{1,1,0,0, 1,1,1,0,0, 2,0,498,200};
    vecs[2] = '{1,1,0,0, 1,1,1,0,0, 3,0,497,200};
    vecs[3] = '{1,0,0,0, 1,1,0,0,0, 3,1,497,199};
    vecs[4] = '{0,0,1,1, 0,0,0,1,1, 2,1,498,199};
    vecs[5] = '{0,0,1,0, 0,0,0,1,1, 2,0,498,200};
    vecs[6] = '{0,0,1,0, 0,0,0,1,0, 2,0,498,200};
    vecs[7] = '{1,1,1,1, 1,1,1,1,1, 2,0,498,200};
    vecs[8] = '{0,0,0,0, 0,0,0,0,0, 2,0,498,200};
    vecs[9] = '{1,1,1,0, 1,1,1,1,0, 3,0,497,200};

    rst_n = 1'b0;
    hour  = 5'd9;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst ready", int'(pif.entry_ready), 0);
    chk("rst uni_cap", int'(uni_cap), 500);
    chk("rst pub_cap", int'(pub_cap), 200);
    chk("rst uni_vac", int'(uni_vac), 500);
    chk("rst pub_vac", int'(pub_vac), 200);
    chk_counts("rst", 0, 0);
    chk("rst full", int'({uni_full, pub_full}), 0);
    chk("rst done", int'({pif.entry_done, pif.exit_done}), 0);
    chk("rst open", int'(open), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst ready", int'(pif.entry_ready), 1);
    chk("post rst open", int'(open), 1);

    // Basic entry/exit behaviour at hour 9.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].ev, vecs[i].eu, vecs[i].xv, vecs[i].xu);
      chk($sformatf("v%0d entry_done", i), int'(pif.entry_done), int'(vecs[i].edone));
      chk($sformatf("v%0d grant", i),      int'(pif.entry_grant), int'(vecs[i].grant));
      if (vecs[i].grant)
        chk($sformatf("v%0d zone", i),     int'(pif.entry_zone), int'(vecs[i].zone));
      chk($sformatf("v%0d exit_done", i),  int'(pif.exit_done), int'(vecs[i].xdone));
      chk($sformatf("v%0d exit_ok", i),    int'(pif.exit_ok), int'(vecs[i].ok));
      chk_counts($sformatf("v%0d", i), vecs[i].ucnt, vecs[i].pcnt);
      chk($sformatf("v%0d uni_vac", i),    int'(uni_vac), vecs[i].uvac);
      chk($sformatf("v%0d pub_vac", i),    int'(pub_vac), vecs[i].pvac);
    end

    // Fill uni zone, then overflow into public.
    burst(1'b1, 1'b1, 1'b0, 1'b0, 497);
    chk_counts("uni fill", 500, 0);
    chk("uni fill full", int'(uni_full), 1);
    chk("uni fill vac", int'(uni_vac), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("overflow grant", int'(pif.entry_grant), 1);
    chk("overflow zone", int'(pif.entry_zone), 0);
    chk_counts("overflow", 500, 1);
    burst(1'b1, 1'b0, 1'b0, 1'b0, 199);
    chk("pub fill full", int'(pub_full), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("both full uni done", int'(pif.entry_done), 1);
    chk("both full uni grant", int'(pif.entry_grant), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("both full pub grant", int'(pif.entry_grant), 0);
    chk_counts("both full", 500, 200);

    // Migration on ramp-down at 13:00.
    burst(1'b0, 1'b0, 1'b1, 1'b1, 20);
    burst(1'b0, 1'b0, 1'b1, 1'b0, 190);
    hour = 5'd12;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("h12 ready", int'(pif.entry_ready), 1);
    chk_counts("h12", 480, 10);
    hour = 5'd13;
    @(posedge clk); #1;
    chk("reconfig ready", int'(pif.entry_ready), 0);
    chk("reconfig exit_ready", int'(pif.exit_ready), 0);
    chk("reconfig open", int'(open), 0);
    @(posedge clk); #1;
    chk("h13 ready", int'(pif.entry_ready), 1);
    chk("h13 open", int'(open), 1);
    chk_counts("h13", 450, 40);
    chk("h13 uni_cap", int'(uni_cap), 450);
    chk("h13 pub_cap", int'(pub_cap), 250);
    chk("h13 uni_full", int'(uni_full), 1);

    // Jump to 16:00, fill public, then morning re-grow without back-migration.
    hour = 5'd16;
    @(posedge clk); @(posedge clk); #1;
    chk_counts("h16", 200, 290);
    chk("h16 uni_cap", int'(uni_cap), 200);
    chk("h16 pub_cap", int'(pub_cap), 500);
    burst(1'b1, 1'b0, 1'b0, 1'b0, 210);
    chk_counts("h16 fill", 200, 500);
    chk("h16 pub_full", int'(pub_full), 1);
    hour = 5'd23;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("h23 uni_cap", int'(uni_cap), 200);
    chk("h23 ready", int'(pif.entry_ready), 1);
    hour = 5'd7;
    @(posedge clk); #1;
    chk("h7 reconfig ready", int'(pif.entry_ready), 0);
    @(posedge clk); #1;
    chk("h7 uni_cap", int'(uni_cap), 500);
    chk("h7 pub_cap", int'(pub_cap), 200);
    chk_counts("h7", 200, 500);
    chk("h7 pub_full", int'(pub_full), 1);
    chk("h7 pub_vac", int'(pub_vac), 0);
    chk("h7 uni_vac", int'(uni_vac), 300);
    chk("h7 open", int'(open), 0);
    hour = 5'd8;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("h8 open", int'(open), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("h8 pub denied", int'(pif.entry_grant), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("h8 uni grant", int'(pif.entry_grant), 1);
    chk("h8 uni zone", int'(pif.entry_zone), 1);
    chk_counts("h8", 201, 500);

    // Simultaneous public exit+entry with the public zone exactly full.
    hour = 5'd10;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    burst(1'b0, 1'b0, 1'b1, 1'b0, 300);
    chk("h10 pub_full", int'(pub_full), 1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("simul done", int'({pif.entry_done, pif.exit_done}), 3);
    chk("simul ok", int'(pif.exit_ok), 1);
    chk("simul grant", int'(pif.entry_grant), 1);
    chk("simul zone", int'(pif.entry_zone), 0);
    chk_counts("simul", 201, 200);
    burst(1'b0, 1'b0, 1'b1, 1'b1, 201);

    // Closed hours: entry denied, exits still served, underflow flagged.
    hour = 5'd6;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("h6 open", int'(open), 0);
    chk("h6 ready", int'(pif.entry_ready), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("h6 entry done", int'(pif.entry_done), 1);
    chk("h6 entry grant", int'(pif.entry_grant), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("h6 underflow done", int'(pif.exit_done), 1);
    chk("h6 underflow ok", int'(pif.exit_ok), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("h6 pub exit ok", int'(pif.exit_ok), 1);
    chk_counts("h6", 0, 199);

    // Asynchronous reset with a done pulse in flight.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("pre rst exit_done", int'(pif.exit_done), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst done", int'({pif.entry_done, pif.exit_done}), 0);
    chk("mid rst ok", int'({pif.exit_ok, pif.entry_grant}), 0);
    chk("mid rst ready", int'(pif.entry_ready), 0);
    chk_counts("mid rst", 0, 0);
    chk("mid rst caps", int'({uni_cap, pub_cap}), int'({10'd500, 10'd200}));
    chk("mid rst vacs", int'({uni_vac, pub_vac}), int'({10'd500, 10'd200}));
    @(posedge clk); #1;
    chk("held rst done", int'(pif.exit_done), 0);
    chk_counts("held rst", 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
